// File: rtl/foc_current_frontend.sv
// ============================================================================
// foc_current_frontend : ADC offset calibration, Q-format scaling, A/B/C frame
// assembly and ready-gated launch to the FOC core. Option macro: CURR_TRIP_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module foc_current_frontend #(
  parameter int D_WIDTH    = 19,
  parameter int Q_BITS     = 15,
  parameter int ADC_BITS   = 12,
  parameter int CAL_LOG2   = 4,
  parameter int TRIP_LIMIT = 29491
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       adc_valid,
  input  logic [1:0]                 adc_ch,
  input  logic [ADC_BITS-1:0]        adc_data,
  input  logic                       top_ready,
  output logic signed [D_WIDTH-1:0]  currA_out,
  output logic signed [D_WIDTH-1:0]  currB_out,
  output logic signed [D_WIDTH-1:0]  currC_out,
  output logic                       curr_valid,
  output logic                       cal_done,
  output logic [7:0]                 overrun_cnt,
  output logic                       trip
);

  localparam int ACC_W = ADC_BITS + CAL_LOG2;
  localparam int SHIFT = Q_BITS - (ADC_BITS - 1);
  localparam logic signed [ADC_BITS:0] D_MAX = (ADC_BITS+1)'(2**(ADC_BITS-1) - 1);
  localparam logic signed [ADC_BITS:0] D_MIN = (ADC_BITS+1)'(-(2**(ADC_BITS-1)));

  typedef enum logic {ST_CAL = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic [ACC_W-1:0]            acc_q  [3];
  logic [ACC_W-1:0]            acc_d  [3];
  logic [CAL_LOG2:0]           cnt_q  [3];
  logic [CAL_LOG2:0]           cnt_d  [3];
  logic signed [D_WIDTH-1:0]   coll_q [3];
  logic signed [D_WIDTH-1:0]   coll_d [3];
  logic signed [D_WIDTH-1:0]   pend_q [3];
  logic signed [D_WIDTH-1:0]   pend_d [3];
  logic signed [D_WIDTH-1:0]   out_q  [3];
  logic signed [D_WIDTH-1:0]   out_d  [3];
  logic [2:0]                  flag_q, flag_d;
  logic                        pending_q, pending_d;
  logic                        valid_q, valid_d;
  logic [7:0]                  ovr_q, ovr_d;

  logic [2:0]                  w_sel;
  logic [2:0]                  w_cal_full;
  logic [ADC_BITS-1:0]         w_off;
  logic signed [ADC_BITS:0]    w_d;
  logic signed [ADC_BITS-1:0]  w_clamp;
  logic signed [D_WIDTH-1:0]   w_ext;
  logic signed [D_WIDTH-1:0]   w_conv;
  logic                        w_launch;
  logic                        w_tripped;

  // Channel decode and offset lookup; offsets are the frozen accumulator means.
  always_comb begin
    w_sel = 3'b000;
    w_off = '0;
    case (adc_ch)
      2'd0: begin w_sel = {2'b00, adc_valid}; w_off = acc_q[0][ACC_W-1:CAL_LOG2]; end
      2'd1: begin w_sel = {1'b0, adc_valid, 1'b0}; w_off = acc_q[1][ACC_W-1:CAL_LOG2]; end
      2'd2: begin w_sel = {adc_valid, 2'b00}; w_off = acc_q[2][ACC_W-1:CAL_LOG2]; end
      default: begin w_sel = 3'b000; w_off = '0; end
    endcase
    for (int i = 0; i < 3; i++) w_cal_full[i] = cnt_q[i][CAL_LOG2];
  end

  assign w_d = $signed({1'b0, adc_data}) - $signed({1'b0, w_off});

  always_comb begin
    if (w_d > D_MAX)      w_clamp = D_MAX[ADC_BITS-1:0];
    else if (w_d < D_MIN) w_clamp = D_MIN[ADC_BITS-1:0];
    else                  w_clamp = w_d[ADC_BITS-1:0];
    w_ext  = {{(D_WIDTH-ADC_BITS){w_clamp[ADC_BITS-1]}}, w_clamp};
    w_conv = w_ext <<< SHIFT;
  end

`ifdef CURR_TRIP_EN
  localparam logic signed [D_WIDTH-1:0] TRIP_HI = D_WIDTH'(TRIP_LIMIT);
  localparam logic signed [D_WIDTH-1:0] TRIP_LO = D_WIDTH'(-TRIP_LIMIT);
  logic trip_q;
  logic w_over;
  assign w_over = (state_q == ST_RUN) && (|w_sel) && ((w_conv > TRIP_HI) || (w_conv < TRIP_LO));
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) trip_q <= 1'b0;
    else       trip_q <= trip_q | w_over;
  end
  assign w_tripped = trip_q;
`else
  assign w_tripped = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    coll_d    = coll_q;
    pend_d    = pend_q;
    out_d     = out_q;
    flag_d    = flag_q;
    pending_d = pending_q;
    valid_d   = 1'b0;
    ovr_d     = ovr_q;
    w_launch  = 1'b0;
    case (state_q)
      ST_CAL: begin
        if (&w_cal_full) begin
          state_d = ST_RUN;
        end else begin
          for (int i = 0; i < 3; i++) begin
            if (w_sel[i] && !w_cal_full[i]) begin
              acc_d[i] = acc_q[i] + ACC_W'(adc_data);
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
      end
      ST_RUN: begin
        // Blocking after a pulse keeps a re-filled pending frame off the next cycle.
        w_launch = pending_q && top_ready && !valid_q && !w_tripped;
        if (w_launch) begin
          out_d     = pend_q;
          valid_d   = 1'b1;
          pending_d = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
          if (w_sel[i]) begin
            coll_d[i] = w_conv;
            flag_d[i] = 1'b1;
          end
        end
        if (&flag_d) begin
          pend_d    = coll_d;
          pending_d = 1'b1;
          flag_d    = 3'b000;
          if (pending_q && !w_launch && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
        end
        if (w_tripped) pending_d = 1'b0;
      end
      default: state_d = ST_CAL;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= ST_CAL;
      flag_q    <= 3'b000;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      ovr_q     <= 8'd0;
      for (int i = 0; i < 3; i++) begin
        acc_q[i]  <= '0;
        cnt_q[i]  <= '0;
        coll_q[i] <= '0;
        pend_q[i] <= '0;
        out_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      flag_q    <= flag_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      coll_q    <= coll_d;
      pend_q    <= pend_d;
      out_q     <= out_d;
    end
  end

  assign currA_out   = out_q[0];
  assign currB_out   = out_q[1];
  assign currC_out   = out_q[2];
  assign curr_valid  = valid_q;
  assign cal_done    = (state_q == ST_RUN);
  assign overrun_cnt = ovr_q;
  assign trip        = w_tripped;

endmodule

`default_nettype wire
